mcu_int_ctrl: RTL and testbench

- 8051-style interrupt controller between the interrupt/timer sources and the CPU instruction sequencer.
- Synchronises external interrupt pins and latches edge or level events and timer overflow flags.
- Resolves two-level IP priority with fixed in-level polling order, then presents one vector to the CPU with a req/ack handshake.
- Tracks in-service levels so RETI re-enables lower or equal priority.

---
 rtl/mcu_int_pkg.sv | 37 +++
 rtl/mcu_int_extsync.sv | 49 ++++
 rtl/mcu_int_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mcu_int_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_int_pkg.sv
// Shared constants, FSM encoding and vector helper for the 8051-style interrupt controller.
package mcu_int_pkg;

  localparam int unsigned NUM_SRC = 5;

  // Source index doubles as polling order: lower index wins within a level.
  localparam logic [2:0] SRC_IE0 = 3'd0;
  localparam logic [2:0] SRC_TF0 = 3'd1;
  localparam logic [2:0] SRC_IE1 = 3'd2;
  localparam logic [2:0] SRC_TF1 = 3'd3;
  localparam logic [2:0] SRC_SI  = 3'd4;

  localparam int unsigned IE_EA  = 7;
  localparam int unsigned IE_ES  = 4;
  localparam int unsigned IE_ET1 = 3;
  localparam int unsigned IE_EX1 = 2;
  localparam int unsigned IE_ET0 = 1;
  localparam int unsigned IE_EX0 = 0;

  localparam int unsigned IP_PS  = 4;
  localparam int unsigned IP_PT1 = 3;
  localparam int unsigned IP_PX1 = 2;
  localparam int unsigned IP_PT0 = 1;
  localparam int unsigned IP_PX0 = 0;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } int_state_e;

  function automatic logic [15:0] vec_addr(input logic [2:0]  idx,
                                           input logic [15:0] base,
                                           input logic [15:0] stride);
    return base + 16'(idx) * stride;
  endfunction

endpackage

// File: rtl/mcu_int_extsync.sv
// External interrupt pin synchroniser with falling-edge latch or low-level follow.
module mcu_int_extsync
  import mcu_int_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  input  logic edge_mode,
  input  logic clr,
  output logic flag
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   flag_q;
  logic                   flag_d;
  logic                   synced;
  logic                   fall;

  assign synced = sync_q[SYNC_STAGES-1];
  assign fall   = prev_q & ~synced;

  // A new edge in the same cycle as an ack clear keeps the flag set.
  always_comb begin
    flag_d = flag_q;
    if (edge_mode) begin
      flag_d = fall | (flag_q & ~clr);
    end else begin
      flag_d = ~synced;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      flag_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_n};
      prev_q <= synced;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/mcu_int_ctrl.sv
// 8051-style interrupt controller: flag latching, two-level priority, req/ack to the CPU.
// Define MCU_INT_SERIAL_EN to add the serial (RI|TI) source on port ri_ti.
module mcu_int_ctrl
  import mcu_int_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic [15:0] VECTOR_BASE   = 16'h0003,
  parameter logic [15:0] VECTOR_STRIDE = 16'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int0_n,
  input  logic        int1_n,
  input  logic        tf0_set,
  input  logic        tf1_set,
  input  logic [7:0]  ie,
  input  logic [4:0]  ip,
  input  logic [1:0]  it,
  input  logic        int_ack,
  input  logic        reti,
`ifdef MCU_INT_SERIAL_EN
  input  logic        ri_ti,
`endif
  output logic        int_req,
  output logic [15:0] int_vector,
  output logic [3:0]  flags,
  output logic [1:0]  in_service
);

  int_state_e         state_q, state_d;
  logic [2:0]         win_idx_q, win_idx_d;
  logic               win_hi_q, win_hi_d;
  logic [15:0]        vec_q, vec_d;
  logic [1:0]         is_q, is_d;
  logic [1:0]         tf_q;

  logic               ie0_flag, ie1_flag, si_flag;
  logic [NUM_SRC-1:0] pend, elig, hi_elig, lo_elig, pick, clr;
  logic [2:0]         win_idx;
  logic               ack_ok;
  logic               unused_ie;

  assign unused_ie = ^ie[6:5];

`ifdef MCU_INT_SERIAL_EN
  assign si_flag = ri_ti;
`else
  assign si_flag = 1'b0;
`endif

  assign ack_ok = (state_q == StReq) & int_ack;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = ack_ok & (win_idx_q == 3'(i));
    end
  end

  mcu_int_extsync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ext0 (
    .clk      (clk),
    .rst      (rst),
    .pin_n    (int0_n),
    .edge_mode(it[0]),
    .clr      (clr[SRC_IE0]),
    .flag     (ie0_flag)
  );

  mcu_int_extsync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ext1 (
    .clk      (clk),
    .rst      (rst),
    .pin_n    (int1_n),
    .edge_mode(it[1]),
    .clr      (clr[SRC_IE1]),
    .flag     (ie1_flag)
  );

  assign pend = {si_flag, tf_q[1], ie1_flag, tf_q[0], ie0_flag};

  // IE and IP bit positions line up with the source index.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = pend[i] & ie[IE_EA] & ie[i] & (ip[i] ? ~is_q[1] : ~|is_q);
    end
  end

  assign hi_elig = elig & ip;
  assign lo_elig = elig & ~ip;
  assign pick    = (|hi_elig) ? hi_elig : lo_elig;

  always_comb begin
    win_idx = SRC_IE0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pick[i]) win_idx = 3'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    win_idx_d = win_idx_q;
    win_hi_d  = win_hi_q;
    vec_d     = vec_q;
    is_d      = is_q;

    // RETI retires the innermost level before a same-cycle ack adds one.
    if (reti) begin
      if (is_q[1]) is_d[1] = 1'b0;
      else         is_d[0] = 1'b0;
    end
    if (ack_ok) begin
      if (win_hi_q) is_d[1] = 1'b1;
      else          is_d[0] = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          state_d   = StReq;
          win_idx_d = win_idx;
          win_hi_d  = |hi_elig;
          vec_d     = vec_addr(win_idx, VECTOR_BASE, VECTOR_STRIDE);
        end
      end
      StReq: begin
        if (ack_ok || !elig[win_idx_q]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      win_idx_q <= SRC_IE0;
      win_hi_q  <= 1'b0;
      vec_q     <= 16'h0000;
      is_q      <= 2'b00;
      tf_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      win_idx_q <= win_idx_d;
      win_hi_q  <= win_hi_d;
      vec_q     <= vec_d;
      is_q      <= is_d;
      tf_q[0]   <= tf0_set | (tf_q[0] & ~clr[SRC_TF0]);
      tf_q[1]   <= tf1_set | (tf_q[1] & ~clr[SRC_TF1]);
    end
  end

  assign int_req    = (state_q == StReq);
  assign int_vector = vec_q;
  assign flags      = {tf_q[1], ie1_flag, tf_q[0], ie0_flag};
  assign in_service = is_q;

endmodule

// File: tb/tb_mcu_int_ctrl.sv
// Directed scenarios plus randomized traffic checked against a behavioural reference model.
module tb_mcu_int_ctrl;

  localparam int unsigned S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        int0_n = 1'b1, int1_n = 1'b1;
  logic        tf0_set = 1'b0, tf1_set = 1'b0;
  logic [7:0]  ie = 8'h00;
  logic [4:0]  ip = 5'h00;
  logic [1:0]  it = 2'b11;
  logic        int_ack = 1'b0, reti = 1'b0;
`ifdef MCU_INT_SERIAL_EN
  logic        ri_ti = 1'b0;
`endif
  logic        int_req;
  logic [15:0] int_vector;
  logic [3:0]  flags;
  logic [1:0]  in_service;

  int total = 0;
  int bad   = 0;

  mcu_int_ctrl #(
    .SYNC_STAGES  (S),
    .VECTOR_BASE  (16'h0003),
    .VECTOR_STRIDE(16'd8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .int0_n    (int0_n),
    .int1_n    (int1_n),
    .tf0_set   (tf0_set),
    .tf1_set   (tf1_set),
    .ie        (ie),
    .ip        (ip),
    .it        (it),
    .int_ack   (int_ack),
    .reti      (reti),
`ifdef MCU_INT_SERIAL_EN
    .ri_ti     (ri_ti),
`endif
    .int_req   (int_req),
    .int_vector(int_vector),
    .flags     (flags),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pending flags, in-service levels, presented source (-1 = none).
  bit          m_pend[5];
  bit          m_hi, m_lo;
  int          m_cur;
  bit          m_cur_hi;
  logic [15:0] m_vec;
  bit          h0[$], h1[$];

  task automatic m_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_hi = 0; m_lo = 0; m_cur = -1; m_cur_hi = 0; m_vec = 16'h0000;
    h0.delete(); h1.delete();
    for (int i = 0; i < S + 2; i++) begin
      h0.push_back(1'b1);
      h1.push_back(1'b1);
    end
  endtask

  function automatic bit m_elig(input int i);
    return m_pend[i] && ie[7] && ie[i] && (ip[i] ? !m_hi : (!m_hi && !m_lo));
  endfunction

  function automatic int m_best();
    int b = -1;
    int bk = 100;
    for (int i = 0; i < 5; i++) begin
      if (m_elig(i) && ((ip[i] ? 0 : 10) + i) < bk) begin
        bk = (ip[i] ? 0 : 10) + i;
        b  = i;
      end
    end
    return b;
  endfunction

  task automatic m_step();
    bit acc, nh, nl, s0, p0, s1, p1;
    bit np[5];
    int b;
`ifdef MCU_INT_SERIAL_EN
    m_pend[4] = ri_ti;
`endif
    h0.push_back(int0_n); void'(h0.pop_front());
    h1.push_back(int1_n); void'(h1.pop_front());
    s0 = h0[1]; p0 = h0[0];
    s1 = h1[1]; p1 = h1[0];
    acc = (m_cur >= 0) && int_ack;
    nh = m_hi; nl = m_lo;
    if (reti) begin
      if (nh) nh = 0;
      else    nl = 0;
    end
    if (acc) begin
      if (m_cur_hi) nh = 1;
      else          nl = 1;
    end
    np = m_pend;
    np[0] = it[0] ? ((p0 && !s0) || (m_pend[0] && !(acc && m_cur == 0))) : !s0;
    np[1] = tf0_set || (m_pend[1] && !(acc && m_cur == 1));
    np[2] = it[1] ? ((p1 && !s1) || (m_pend[2] && !(acc && m_cur == 2))) : !s1;
    np[3] = tf1_set || (m_pend[3] && !(acc && m_cur == 3));
    if (m_cur < 0) begin
      b = m_best();
      if (b >= 0) begin
        m_cur = b;
        m_cur_hi = ip[b];
        m_vec = 16'h0003 + 16'(b * 8);
      end
    end else if (acc || !m_elig(m_cur)) begin
      m_cur = -1;
    end
    m_pend = np;
    m_hi = nh;
    m_lo = nl;
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check("req", 16'(int_req), 16'(m_cur >= 0));
    if (m_cur >= 0) check("vec", int_vector, m_vec);
    check("flags", 16'(flags), 16'({m_pend[3], m_pend[2], m_pend[1], m_pend[0]}));
    check("insvc", 16'(in_service), 16'({m_hi, m_lo}));
    tf0_set = 0; tf1_set = 0; int_ack = 0; reti = 0;
  endtask

  task automatic wait_req(input int max, input string tag);
    int n = 0;
    while (!int_req && n < max) begin
      tick();
      n++;
    end
    check(tag, 16'(int_req), 16'd1);
  endtask

  task automatic ack_reti();
    int_ack = 1; tick();
    reti = 1;    tick();
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 16'(int_req), 16'd0);
    check("rst_vec", int_vector, 16'h0000);
    check("rst_flags", 16'(flags), 16'd0);
    check("rst_insvc", 16'(in_service), 16'd0);
    @(negedge clk);
    rst = 0;

    // Edge on INT0: request on the 4th edge.
    ie = 8'h81; ip = 5'h00; it = 2'b01; int0_n = 0;
    repeat (3) tick();
    check("tp1_early", 16'(int_req), 16'd0);
    tick();
    check("tp1_req", 16'(int_req), 16'd1);
    check("tp1_vec", int_vector, 16'h0003);
    int_ack = 1; tick();
    check("tp1_ackreq", 16'(int_req), 16'd0);
    check("tp1_flag0", 16'(flags[0]), 16'd0);
    check("tp1_insvc", 16'(in_service), 16'h0001);
    int0_n = 1; reti = 1; tick();
    repeat (4) tick();

    // Simultaneous timer overflows: TF0 then TF1.
    ie = 8'h8A; ip = 5'h00; it = 2'b11;
    tf0_set = 1; tf1_set = 1;
    wait_req(4, "tp2_req1");
    check("tp2_vec1", int_vector, 16'h000B);
    ack_reti();
    wait_req(4, "tp2_req2");
    check("tp2_vec2", int_vector, 16'h001B);
    ack_reti();

    // High-priority TF1 preempts low TF0 in service.
    tf0_set = 1;
    wait_req(4, "tp3_req0");
    int_ack = 1; tick();
    ip = 5'b01000; tf1_set = 1;
    wait_req(4, "tp3_preempt");
    check("tp3_vec", int_vector, 16'h001B);
    int_ack = 1; tick();
    check("tp3_insvc", 16'(in_service), 16'h0003);
    tf0_set = 1; repeat (4) tick();
    check("tp3_blk1", 16'(int_req), 16'd0);
    reti = 1; repeat (3) tick();
    check("tp3_blk2", 16'(int_req), 16'd0);
    reti = 1;
    wait_req(4, "tp3_tf0");
    check("tp3_vec0", int_vector, 16'h000B);
    ack_reti();
    ip = 5'h00;

    // Level-mode INT1 re-requests while low, clears on pin release.
    it = 2'b00; ie = 8'h84; int1_n = 0;
    wait_req(6, "tp4_req");
    check("tp4_vec", int_vector, 16'h0013);
    ack_reti();
    wait_req(4, "tp4_rereq");
    check("tp4_vec2", int_vector, 16'h0013);
    int1_n = 1;
    repeat (4) tick();
    check("tp4_flag2", 16'(flags[2]), 16'd0);
    tick();
    check("tp4_noreq", 16'(int_req), 16'd0);
    it = 2'b11;

    // Withdraw when EA drops during REQ.
    ie = 8'h8A; tf0_set = 1;
    wait_req(4, "tp5_req");
    check("tp5_vec", int_vector, 16'h000B);
    ie = 8'h0A; tick();
    check("tp5_wdraw", 16'(int_req), 16'd0);
    check("tp5_flag1", 16'(flags[1]), 16'd1);
    ie = 8'h8A;
    wait_req(4, "tp5_rereq");
    ack_reti();

    // Asynchronous reset with a high level in service and flags pending.
    ip = 5'b00010; tf0_set = 1;
    wait_req(4, "tp6_req");
    int_ack = 1; tick();
    check("tp6_insvc", 16'(in_service), 16'h0002);
    tf0_set = 1; tf1_set = 1; tick();
    #2 rst = 1;
    #1;
    check("tp6_req", 16'(int_req), 16'd0);
    check("tp6_vec", int_vector, 16'h0000);
    check("tp6_flags", 16'(flags), 16'd0);
    check("tp6_insvc0", 16'(in_service), 16'd0);
    m_reset();
    @(negedge clk);
    rst = 0;
    repeat (6) tick();
    check("tp6_quiet", 16'(int_req), 16'd0);

    // Randomized traffic.
    ie = 8'h9F; ip = 5'h00; it = 2'b11;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) int0_n = ~int0_n;
      if ($urandom_range(7) == 0) int1_n = ~int1_n;
      tf0_set = ($urandom_range(15) == 0);
      tf1_set = ($urandom_range(15) == 0);
      if ($urandom_range(63) == 0) begin
        ie = 8'($urandom);
        ie[7] = ($urandom_range(3) != 0);
      end
      if ($urandom_range(63) == 0) ip = 5'($urandom);
      if ($urandom_range(127) == 0) it = 2'($urandom);
      int_ack = (m_cur >= 0) ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      reti = ($urandom_range(11) == 0);
`ifdef MCU_INT_SERIAL_EN
      if ($urandom_range(15) == 0) ri_ti = ~ri_ti;
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
